// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and datapath constants for the ALU sequencer.
package alu_pkg;

    localparam int WIDTH    = 32;
    localparam int MUL_ITER = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/result handshake bundle between operand source, ALU sequencer and result consumer.
interface alu_seq_ctrl_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one iteration per clock; loads on start, done pulses with the final
// product on the last iteration (32 edges after start). No backpressure: the caller must take it.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam logic [4:0] LAST_ITER = 5'(MUL_ITER - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [4:0]       cnt;
    logic             active;
    logic [WIDTH-1:0] acc_nxt;

    assign acc_nxt = mplier[0] ? acc + mcand : acc;
    // The last iteration's sum is the product; handing it out combinationally saves an edge.
    assign done    = active && (cnt == LAST_ITER);
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == LAST_ITER) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: one request at a time; result valid 1 edge after accept (MUL: 32 edges).
// Result is held in DONE until out_ready; no new request is accepted until the edge after that.
module alu_seq_ctrl
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    alu_seq_ctrl_if.slave  bus
);

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             busy_r;
    logic [WIDTH-1:0] alu_res;
    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign accept        = bus.in_valid && in_ready_r && (state == ST_IDLE);
    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;

    always_comb begin
        alu_res = '0;
        unique case (op_r)
            OP_AND:  alu_res = a_r & b_r;
            OP_OR:   alu_res = a_r | b_r;
            OP_XOR:  alu_res = a_r ^ b_r;
            OP_NOR:  alu_res = ~(a_r | b_r);
            OP_SLT:  alu_res = ($signed(a_r) < $signed(b_r)) ? 32'd1 : 32'd0;
            OP_ADD:  alu_res = a_r + b_r;
            OP_SUB:  alu_res = a_r - b_r;
            default: alu_res = '0;
        endcase
    end

    // Operands come straight off the bus on the accept edge so iteration 0 lands on E1.
    alu_mul_seq u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && (bus.alu_op == OP_MUL)),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r       <= bus.alu_op;
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        state      <= (bus.alu_op == OP_MUL) ? ST_MUL : ST_EXEC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    result_r    <= alu_res;
                    zero_r      <= (alu_res == '0);
                    out_valid_r <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result_r    <= mul_prod;
                        zero_r      <= (mul_prod == '0);
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and randomized checks of alu_seq_ctrl against an arithmetic reference model.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] full;
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: begin
                full = 64'(a) * 64'(b);
                return full[31:0];
            end
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        bit          seen;
        exp = ref_alu(op, a, b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.in_ready) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, " accept"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.alu_op   = 3'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, " in_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), (op == OP_MUL) ? 32'd32 : 32'd1);
        chk({tag, " result"}, bus.result, exp);
        chk({tag, " zero"}, {31'd0, bus.zero}, {31'd0, exp == 32'd0});
        held = bus.result;
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk({tag, " held_result"}, bus.result, held);
            chk({tag, " held_valid"}, {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, " ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] snap_res;
        logic        snap_zero;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rose;
        n_tests = 0;
        n_fail  = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst result", bus.result, 32'd0);
        chk("rst zero", {31'd0, bus.zero}, 32'd0);
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel in_ready", {31'd0, bus.in_ready}, 32'd1);

        do_op("xor",  OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 0);
        do_op("add",  OP_ADD, 32'hFFFFFFFF, 32'h00000001, 0);
        do_op("sub0", OP_SUB, 32'h12345678, 32'h12345678, 0);
        do_op("sub1", OP_SUB, 32'h00000000, 32'h00000001, 0);
        do_op("slt",  OP_SLT, 32'hFFFFFFFF, 32'h00000001, 0);
        do_op("sltn", OP_SLT, 32'h00000001, 32'hFFFFFFFF, 0);
        do_op("slte", OP_SLT, 32'h00000005, 32'h00000005, 0);
        do_op("nor",  OP_NOR, 32'h0000FFFF, 32'h00FF0000, 0);
        do_op("mul1", OP_MUL, 32'h00010001, 32'h0000FFFF, 0);
        do_op("mul2", OP_MUL, 32'h80000000, 32'h00000002, 0);
        do_op("mul3", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

        // Backpressure: result waits while a new request is pending on the input.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_op = OP_ADD; bus.a = 32'd7; bus.b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.alu_op = OP_XOR; bus.a = 32'hA5A5A5A5; bus.b = 32'h0000FFFF;
        @(posedge clk);
        @(negedge clk);
        chk("bp first", bus.result, 32'd16);
        snap_res  = bus.result;
        snap_zero = bus.zero;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp result", bus.result, snap_res);
            chk("bp zero", {31'd0, bus.zero}, {31'd0, snap_zero});
            chk("bp valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp hs valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp hs busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp next accept", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp next result", bus.result, 32'hA5A55A5A);
        chk("bp next valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset in the middle of a multiply.
        bus.in_valid = 1'b1; bus.alu_op = OP_MUL; bus.a = 32'h1234; bus.b = 32'h5678;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rmul in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rmul busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rmul rel in_ready", {31'd0, bus.in_ready}, 32'd1);
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) rose = 1'b1;
            @(negedge clk);
        end
        chk("rmul no valid", {31'd0, rose}, 32'd0);
        chk("rmul result", bus.result, 32'd0);
        do_op("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 0);

        for (int n = 0; n < 30; n++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            do_op("rand", rop, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
